sync_fifo_flags: RTL

//  Parametrised successor of the single-clock FIFO: circular buffer of DEPTH words x DATA_WIDTH bits

---
 rtl/sync_fifo_flags.sv | 98 +++++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is 1-cycle registered read.
module sync_fifo_flags #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH_FIFO = 16,
  parameter int unsigned AF_LEVEL   = 12,
  parameter int unsigned AE_LEVEL   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         input_data,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         output_data,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic [$clog2(DEPTH_FIFO):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned PtrW = $clog2(DEPTH_FIFO);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [CntW-1:0] Depth   = CntW'(DEPTH_FIFO);
  localparam logic [CntW-1:0] AfLevel = CntW'(AF_LEVEL);
  localparam logic [CntW-1:0] AeLevel = CntW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_FIFO];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  overflow_q, underflow_q;
  logic                  wr_ok, rd_ok;

  assign empty        = (count_q == '0);
  assign full         = (count_q == Depth);
  assign almost_empty = (count_q <= AeLevel);
  assign almost_full  = (count_q >= AfLevel);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A read frees a slot in the same cycle, so a write into a full FIFO is legal alongside it.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CntW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem_q[wr_ptr_q] <= input_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q     <= count_d;
      overflow_q  <= wr_en & ~wr_ok;
      underflow_q <= rd_en & empty;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always visible; while empty it shows whatever sits at rd_ptr.
  assign output_data = mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (rd_ok) begin
      rdata_q <= mem_q[rd_ptr_q];
    end
  end

  assign output_data = rdata_q;
`endif

endmodule
